// File: rtl/m_imem_loader.sv
// Byte-stream program loader: assembles a framed little-endian byte stream into
// 32-bit words and writes them to word addresses 0..N-1 of the instruction memory.
// Latency: a word is written (r_we pulse) one cycle after the edge that accepts
//   its 4th byte.
// Backpressure: r_dready is high while a frame is in progress, so one byte per
//   cycle can be sustained. It is low in DONE/ERR until w_start re-arms the loader.
//
// Ports:
//   w_clk, w_rst          clock, synchronous active-high reset
//   w_din, w_dvalid       incoming byte; it transfers when w_dvalid & r_dready
//   r_dready              loader can accept a byte this cycle
//   w_start               one-cycle re-arm pulse (only honoured in DONE/ERR)
//   r_addr, r_we, r_wdata memory write port (word address, enable, data)
//   r_cpu_rst             processor reset; held high until a verified load
//   r_done, r_err         frame loaded and verified / frame rejected
//
// Frame: count N (16-bit LE), 4N data bytes (LE per word), XOR-of-data checksum.

module m_imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [7:0]        w_din,
  input  logic              w_dvalid,
  output logic              r_dready,
  input  logic              w_start,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_we,
  output logic [31:0]       r_wdata,
  output logic              r_cpu_rst,
  output logic              r_done,
  output logic              r_err
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Largest legal word count: the whole memory. 17 bits so that 2^16 would still fit.
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [7:0]        r_cnt_lo;   // count low byte, held until the high byte arrives
  logic [ADDR_W-1:0] r_idx;      // index of the word being assembled
  logic [ADDR_W-1:0] r_last;     // N-1, index of the final word
  logic [1:0]        r_lane;     // byte lane of the next data byte
  logic [23:0]       r_word;     // lanes 0..2 of the word being assembled
  logic [7:0]        r_csum;     // running XOR of data bytes

  logic              w_xfer;
  logic [16:0]       w_n;
  logic              w_n_bad;
  logic              w_last_byte;
  logic              w_dready_nxt;

  assign w_xfer      = w_dvalid & r_dready;
  assign w_n         = {1'b0, w_din, r_cnt_lo};
  assign w_n_bad     = (w_n == 17'd0) || (w_n > MAX_N);
  assign w_last_byte = (r_lane == 2'd3) && (r_idx == r_last);

  // Next-state logic. Reset priority is handled in the sequential block.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_xfer) w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        if (w_xfer) w_state_nxt = w_n_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_xfer && w_last_byte) w_state_nxt = S_SUM;
      end
      S_SUM: begin
        // r_csum already holds every data byte; the checksum byte itself is compared.
        if (w_xfer) w_state_nxt = (w_din == r_csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (w_start) w_state_nxt = S_HDR0;
      end
      default: w_state_nxt = S_HDR0;
    endcase
  end

  // The ready flag is registered from the next state so that it is already
  // correct in the first cycle of each state (including dropping on entry to DONE/ERR).
  assign w_dready_nxt = (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                        (w_state_nxt == S_DATA) || (w_state_nxt == S_SUM);

  // Control state and status outputs.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state   <= S_HDR0;
      r_dready  <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dready  <= w_dready_nxt;
      r_cpu_rst <= (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      r_err     <= (w_state_nxt == S_ERR);
    end
  end

  // Datapath: header capture, word assembly, checksum and memory write port.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_cnt_lo <= 8'd0;
      r_idx    <= '0;
      r_last   <= '0;
      r_lane   <= 2'd0;
      r_word   <= 24'd0;
      r_csum   <= 8'd0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= 32'd0;
    end else begin
      // Write enable is a single-cycle pulse; address and data hold otherwise.
      r_we <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_xfer) r_cnt_lo <= w_din;
        end
        S_HDR1: begin
          if (w_xfer) begin
            // Only meaningful when the count is legal (1..2^ADDR_W), so N-1 fits.
            r_last <= ADDR_W'({w_din, r_cnt_lo} - 16'd1);
            r_idx  <= '0;
            r_lane <= 2'd0;
            r_csum <= 8'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ w_din;
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= w_din;
              2'd1: r_word[15:8]  <= w_din;
              2'd2: r_word[23:16] <= w_din;
              default: begin
                r_we    <= 1'b1;
                r_addr  <= r_idx;
                r_wdata <= {w_din, r_word};
                // Wraps to 0 only after the final word of a full-size frame,
                // by which point the state has left S_DATA.
                r_idx   <= r_idx + 1'b1;
              end
            endcase
          end
        end
        S_DONE, S_ERR: begin
          if (w_start) begin
            r_idx  <= '0;
            r_lane <= 2'd0;
            r_csum <= 8'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: drives framed byte streams and checks the
// memory write port, status flags and processor reset.
// Inputs are driven #1 after the rising edge; outputs are sampled there too.

module tb_m_imem_loader;

  localparam int ADDR_W = 12;
  localparam int MAXW   = 4096;

  logic              w_clk = 1'b0;
  logic              w_rst;
  logic [7:0]        w_din;
  logic              w_dvalid;
  logic              r_dready;
  logic              w_start;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  m_imem_loader #(.ADDR_W(ADDR_W)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_din     (w_din),
    .w_dvalid  (w_dvalid),
    .r_dready  (r_dready),
    .w_start   (w_start),
    .r_addr    (r_addr),
    .r_we      (r_we),
    .r_wdata   (r_wdata),
    .r_cpu_rst (r_cpu_rst),
    .r_done    (r_done),
    .r_err     (r_err)
  );

  always #5 w_clk = ~w_clk;

  int checks   = 0;
  int failures = 0;

  // Memory image built from observed writes, sampled mid-cycle.
  logic [31:0]       tb_mem [0:MAXW-1];
  logic [31:0]       src    [0:MAXW-1];
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [ADDR_W-1:0] addr_log [0:7];

  always @(negedge w_clk) begin
    if (r_we) begin
      tb_mem[r_addr] = r_wdata;
      if (wr_cnt < 8) addr_log[wr_cnt] = r_addr;
      wr_cnt    = wr_cnt + 1;
      last_addr = r_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  // Wait (bounded) for the loader to be ready, then present one byte for one edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!r_dready && n < 200) begin
      tick();
      n++;
    end
    if (!r_dready) check_eq("dready_timeout", {31'd0, r_dready}, 32'd1);
    w_din    = b;
    w_dvalid = 1'b1;
    tick();
    w_dvalid = 1'b0;
  endtask

  // Sends a frame of n words taken from src[]; the checksum is XORed with sum_flip.
  task automatic send_frame(input int n, input logic [7:0] sum_flip,
                            input bit gaps, input bit chk_rdy);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] nn;
    logic [31:0] w;
    cs = 8'd0;
    nn = 16'(n);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      w = src[i];
      for (int l = 0; l < 4; l++) begin
        b  = w[l*8 +: 8];
        cs = cs ^ b;
        if (gaps) begin
          while ($urandom_range(0, 9) < 3) tick();
        end
        send_byte(b);
        if (chk_rdy) check_eq("dready_stream", {31'd0, r_dready}, 32'd1);
      end
    end
    send_byte(cs ^ sum_flip);
  endtask

  task automatic start_pulse();
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    repeat (3) tick();
    w_rst = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    w_rst    = 1'b1;
    w_din    = 8'd0;
    w_dvalid = 1'b0;
    w_start  = 1'b0;
    repeat (3) tick();

    // Reset state.
    check_eq("rst_addr",    32'(r_addr), 32'd0);
    check_eq("rst_we",      {31'd0, r_we}, 32'd0);
    check_eq("rst_wdata",   r_wdata, 32'd0);
    check_eq("rst_cpu_rst", {31'd0, r_cpu_rst}, 32'd1);
    check_eq("rst_done",    {31'd0, r_done}, 32'd0);
    check_eq("rst_err",     {31'd0, r_err}, 32'd0);
    check_eq("rst_dready",  {31'd0, r_dready}, 32'd0);
    w_rst = 1'b0;
    check_eq("dready_before_edge", {31'd0, r_dready}, 32'd0);
    tick();
    check_eq("dready_after_rst", {31'd0, r_dready}, 32'd1);

    // Single word 0x20010020; data XOR = 0x20^0x00^0x01^0x20 = 0x01.
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    check_eq("t1_no_early_we", {31'd0, r_we}, 32'd0);
    send_byte(8'h20);
    check_eq("t1_we",    {31'd0, r_we}, 32'd1);
    check_eq("t1_addr",  32'(r_addr), 32'd0);
    check_eq("t1_wdata", r_wdata, 32'h2001_0020);
    send_byte(8'h01);
    check_eq("t1_done",    {31'd0, r_done}, 32'd1);
    check_eq("t1_cpu_rst", {31'd0, r_cpu_rst}, 32'd0);
    check_eq("t1_dready",  {31'd0, r_dready}, 32'd0);
    check_eq("t1_hold_addr",  32'(r_addr), 32'd0);
    check_eq("t1_hold_wdata", r_wdata, 32'h2001_0020);
    start_pulse();
    check_eq("t1_rearm_done",    {31'd0, r_done}, 32'd0);
    check_eq("t1_rearm_cpu_rst", {31'd0, r_cpu_rst}, 32'd1);

    // N=3, words 1,2,3 streamed back-to-back; checksum 0x00.
    src[0] = 32'd1; src[1] = 32'd2; src[2] = 32'd3;
    base = wr_cnt;
    send_frame(3, 8'h00, 1'b0, 1'b1);
    check_eq("t2_writes", 32'(wr_cnt - base), 32'd3);
    check_eq("t2_addr0", 32'(addr_log[base]),   32'd0);
    check_eq("t2_addr1", 32'(addr_log[base+1]), 32'd1);
    check_eq("t2_addr2", 32'(addr_log[base+2]), 32'd2);
    check_eq("t2_mem2",  tb_mem[2], 32'd3);
    check_eq("t2_done",  {31'd0, r_done}, 32'd1);
    start_pulse();

    // Same frame, checksum forced to 0xFF.
    base = wr_cnt;
    send_frame(3, 8'hFF, 1'b0, 1'b0);
    check_eq("t3_writes",  32'(wr_cnt - base), 32'd3);
    check_eq("t3_err",     {31'd0, r_err}, 32'd1);
    check_eq("t3_done",    {31'd0, r_done}, 32'd0);
    check_eq("t3_cpu_rst", {31'd0, r_cpu_rst}, 32'd1);
    start_pulse();
    check_eq("t3_rearm_err",    {31'd0, r_err}, 32'd0);
    check_eq("t3_rearm_dready", {31'd0, r_dready}, 32'd1);

    // Illegal counts: N=0 and N=4097.
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h00);
    check_eq("t4_n0_err", {31'd0, r_err}, 32'd1);
    start_pulse();
    send_byte(8'h01); send_byte(8'h10);
    check_eq("t4_n4097_err", {31'd0, r_err}, 32'd1);
    repeat (3) tick();
    check_eq("t4_no_writes", 32'(wr_cnt - base), 32'd0);
    start_pulse();

    // Reset after 6 data bytes of an N=2 frame.
    base = wr_cnt;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    w_rst = 1'b1;
    tick();
    check_eq("t5_cpu_rst", {31'd0, r_cpu_rst}, 32'd1);
    check_eq("t5_dready",  {31'd0, r_dready}, 32'd0);
    w_rst = 1'b0;
    tick();
    check_eq("t5_writes", 32'(wr_cnt - base), 32'd1);
    check_eq("t5_addr",   32'(last_addr), 32'd0);
    check_eq("t5_mem0",   tb_mem[0], 32'hDDCC_BBAA);
    src[0] = 32'h1122_3344;
    send_frame(1, 8'h00, 1'b0, 1'b0);
    check_eq("t5_fresh_writes", 32'(wr_cnt - base), 32'd2);
    check_eq("t5_fresh_addr",   32'(last_addr), 32'd0);
    check_eq("t5_fresh_mem0",   tb_mem[0], 32'h1122_3344);
    check_eq("t5_fresh_done",   {31'd0, r_done}, 32'd1);
    start_pulse();

    // Full-size frame with random idle gaps.
    for (int i = 0; i < MAXW; i++) src[i] = $urandom;
    base = wr_cnt;
    send_frame(MAXW, 8'h00, 1'b1, 1'b0);
    check_eq("t6_writes",    32'(wr_cnt - base), 32'(MAXW));
    check_eq("t6_last_addr", 32'(last_addr), 32'hFFF);
    check_eq("t6_done",      {31'd0, r_done}, 32'd1);
    check_eq("t6_cpu_rst",   {31'd0, r_cpu_rst}, 32'd0);
    bad = 0;
    for (int i = 0; i < MAXW; i++) if (tb_mem[i] !== src[i]) bad++;
    check_eq("t6_bad_words", 32'(bad), 32'd0);
    check_eq("t6_mem_last",  tb_mem[MAXW-1], src[MAXW-1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
